// File: rtl/handshake_sync_rx.sv
// -----------------------------------------------------------------------------
// handshake_sync_rx
//
// Receive side of a 4-phase req/ack clock-domain crossing. The foreign request
// (req_in) is brought into the clk domain through a SYNC_STAGES-deep flop
// chain. Once the synchronized request (req_s) is seen, the word on data_in is
// captured. data_in itself is never synchronized: the sender holds it stable
// while req_in is high, and it is only sampled in the cycle qualified by req_s.
// The captured word is offered downstream with a valid/ready handshake. Once
// it is accepted, ack_out is raised to the sender and held until req_s drops.
//
// Ports
//   clk      in   receive-domain clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   allows a new transfer to start (gates IDLE -> OFFER only)
//   req_in   in   4-phase request from the foreign domain (asynchronous)
//   data_in  in   [N-1:0] foreign data, stable while req_in is high
//   rdy_in   in   downstream ready
//   data_out out  [N-1:0] captured word
//   vld_out  out  data_out is valid and offered downstream
//   ack_out  out  4-phase acknowledge to the sender (registered)
//   busy     out  high whenever the FSM is not in IDLE
//   err      out  sticky flag: sender withdrew req before the word was taken
//   xfer_cnt out  [7:0] completed-transfer count, wraps modulo 256
// -----------------------------------------------------------------------------
module handshake_sync_rx #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         req_in,
    input  logic [N-1:0] data_in,
    input  logic         rdy_in,
    output logic [N-1:0] data_out,
    output logic         vld_out,
    output logic         ack_out,
    output logic         busy,
    output logic         err,
    output logic [7:0]   xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 req_s;
    logic [N-1:0]         data_nxt;
    logic                 vld_nxt;
    logic                 ack_nxt;
    logic                 err_nxt;
    logic [7:0]           cnt_nxt;

    // Synchronizer: bit 0 is the metastability-catching flop; the last bit is
    // the only form of req_in that the rest of the logic is allowed to see.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // State and registered outputs. ack_out comes straight from a flop so the
    // sender never sees a combinational glitch on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_out <= '0;
            vld_out  <= 1'b0;
            ack_out  <= 1'b0;
            err      <= 1'b0;
            xfer_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            data_out <= data_nxt;
            vld_out  <= vld_nxt;
            ack_out  <= ack_nxt;
            err      <= err_nxt;
            xfer_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_out;
        vld_nxt   = vld_out;
        ack_nxt   = ack_out;
        err_nxt   = err;
        cnt_nxt   = xfer_cnt;
        case (state)
            IDLE: begin
                // data_in is only trusted once req_s confirms the sender's
                // request has settled in this domain.
                if (ena && req_s) begin
                    data_nxt  = data_in;
                    vld_nxt   = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                // A withdrawn request wins over a simultaneous accept: the
                // sender has already given up, so acknowledging would be wrong.
                if (!req_s) begin
                    err_nxt   = 1'b1;
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (rdy_in) begin
                    vld_nxt   = 1'b0;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = xfer_cnt + 8'd1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                vld_nxt   = 1'b0;
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_handshake_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_handshake_sync_rx
//
// Directed bench for handshake_sync_rx (N=8, SYNC_STAGES=2). Inputs are driven
// 1 time unit after a rising edge and outputs are sampled at the same point,
// so every step() below corresponds to exactly one rising clk edge.
// -----------------------------------------------------------------------------
module tb_handshake_sync_rx;

    localparam int N  = 8;
    localparam int SS = 2;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         req_in;
    logic [N-1:0] data_in;
    logic         rdy_in;
    logic [N-1:0] data_out;
    logic         vld_out;
    logic         ack_out;
    logic         busy;
    logic         err;
    logic [7:0]   xfer_cnt;

    int checks = 0;
    int errors = 0;

    handshake_sync_rx #(.N(N), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .req_in   (req_in),
        .data_in  (data_in),
        .rdy_in   (rdy_in),
        .data_out (data_out),
        .vld_out  (vld_out),
        .ack_out  (ack_out),
        .busy     (busy),
        .err      (err),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One complete transfer with rdy_in held high; every wait is bounded.
    task automatic do_xfer(input logic [7:0] d, input logic [7:0] exp_cnt);
        int k;
        data_in = d;
        req_in  = 1'b1;
        k = 0;
        do begin step(1); k++; end while (!vld_out && k < 10);
        chk("xfer_vld", vld_out, 1'b1);
        chk("xfer_data", data_out, d);
        k = 0;
        do begin step(1); k++; end while (!ack_out && k < 10);
        chk("xfer_ack", ack_out, 1'b1);
        chk("xfer_cnt", xfer_cnt, exp_cnt);
        req_in = 1'b0;
        k = 0;
        do begin step(1); k++; end while (ack_out && k < 10);
        chk("xfer_ack_fall", ack_out, 1'b0);
    endtask

    initial begin
        logic ack_seen;
        rst_n   = 1'b0;
        ena     = 1'b0;
        req_in  = 1'b0;
        data_in = '0;
        rdy_in  = 1'b0;
        #2;
        chk("rst_vld", vld_out, 1'b0);
        chk("rst_ack", ack_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cnt", xfer_cnt, 8'd0);
        chk("rst_data", data_out, 8'd0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // Basic transfer
        ena = 1'b1; rdy_in = 1'b1; data_in = 8'hA5; req_in = 1'b1;
        step(2);
        chk("basic_vld_early", vld_out, 1'b0);
        step(1);
        chk("basic_vld_e3", vld_out, 1'b1);
        chk("basic_data", data_out, 8'hA5);
        step(1);
        chk("basic_ack", ack_out, 1'b1);
        chk("basic_vld_clr", vld_out, 1'b0);
        chk("basic_cnt", xfer_cnt, 8'd1);
        req_in = 1'b0;
        step(2);
        chk("basic_ack_hold", ack_out, 1'b1);
        step(1);
        chk("basic_ack_fall", ack_out, 1'b0);
        chk("basic_busy", busy, 1'b0);

        // Backpressure
        rdy_in = 1'b0; data_in = 8'h96; req_in = 1'b1;
        step(3);
        chk("bp_vld", vld_out, 1'b1);
        data_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("bp_vld_hold", vld_out, 1'b1);
            chk("bp_data_hold", data_out, 8'h96);
            chk("bp_ack_low", ack_out, 1'b0);
        end
        rdy_in = 1'b1;
        step(1);
        chk("bp_ack", ack_out, 1'b1);
        chk("bp_cnt", xfer_cnt, 8'd2);
        req_in = 1'b0;
        step(3);
        chk("bp_ack_fall", ack_out, 1'b0);

        // Protocol error: request withdrawn while the word is still offered
        rdy_in = 1'b0; data_in = 8'h3C; req_in = 1'b1;
        step(3);
        chk("err_vld", vld_out, 1'b1);
        req_in = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1);
            ack_seen |= ack_out;
        end
        chk("err_not_yet", err, 1'b0);
        step(1);
        ack_seen |= ack_out;
        chk("err_set", err, 1'b1);
        chk("err_vld_clr", vld_out, 1'b0);
        chk("err_busy", busy, 1'b0);
        chk("err_cnt", xfer_cnt, 8'd2);
        rdy_in = 1'b1;
        step(4);
        ack_seen |= ack_out;
        chk("err_no_ack", ack_seen, 1'b0);
        do_xfer(8'h5A, 8'd3);
        chk("err_sticky", err, 1'b1);

        // ena gating: request held high with ena low must not start anything
        ena = 1'b0; req_in = 1'b1; data_in = 8'h11;
        step(6);
        chk("ena_busy", busy, 1'b0);
        chk("ena_vld", vld_out, 1'b0);
        req_in = 1'b0;
        step(4);

        // Reset clears err and the count, then 256 transfers wrap it to 0
        rst_n = 1'b0;
        #1;
        chk("rst2_err", err, 1'b0);
        chk("rst2_cnt", xfer_cnt, 8'd0);
        step(1);
        rst_n = 1'b1;
        ena = 1'b1; rdy_in = 1'b1;
        for (int i = 0; i < 256; i++) begin
            do_xfer(8'(i), 8'(i + 1));
        end
        chk("wrap_cnt", xfer_cnt, 8'd0);

        // Reset in ACK, with req_in still high at release
        data_in = 8'hC3; req_in = 1'b1;
        step(4);
        chk("mid_ack", ack_out, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_ack", ack_out, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_vld", vld_out, 1'b0);
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_cnt", xfer_cnt, 8'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("mid_rel_vld_early", vld_out, 1'b0);
        step(1);
        chk("mid_rel_vld", vld_out, 1'b1);
        chk("mid_rel_data", data_out, 8'hC3);
        req_in = 1'b0;
        step(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
